// File: rtl/connect4_pkg.sv
// Shared board geometry, piece encoding and colour constants for the
// Connect-4 pixel renderer.
package connect4_pkg;

  localparam int BOARD_COLS = 7;
  localparam int BOARD_ROWS = 6;
  localparam int NUM_CELLS  = BOARD_COLS * BOARD_ROWS;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } piece_t;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] WHITE  = 3'b111;

  // Flat cell index, row-major with row 0 at the bottom of the board.
  function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return ({3'b000, row} * 6'd7) + {3'b000, col};
  endfunction

endpackage

// File: rtl/connect4_board_store.sv
// Double-buffered board: game logic writes the shadow copy, the renderer reads
// the display copy, which is refreshed only at frame_start.
module connect4_board_store
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_row,
  input  logic [1:0] wr_piece,
  input  logic       clear,
  input  logic       frame_start,
  input  logic [2:0] rd_col,
  input  logic [2:0] rd_row,
  output logic [1:0] rd_piece
);

  logic [NUM_CELLS-1:0][1:0] shadow;
  logic [NUM_CELLS-1:0][1:0] shadow_next;
  logic [NUM_CELLS-1:0][1:0] display;
  logic                      wr_ok;

  assign wr_ok = wr_en && (wr_col < 3'(BOARD_COLS)) && (wr_row < 3'(BOARD_ROWS));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shadow_next = shadow;
    if (clear)
      shadow_next = '0;
    else if (wr_ok)
      shadow_next[cell_index(wr_row, wr_col)] = (wr_piece == 2'd3) ? EMPTY : piece_t'(wr_piece);
  end

  // NOTE: both boards are small flop arrays that must power up empty, so they
  // are reset like ordinary state; <= keeps the copy reading pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      display <= '0;
    end else begin
      shadow <= shadow_next;
      if (frame_start)
        display <= shadow_next;
    end
  end

  always_comb begin
    rd_piece = EMPTY;
    if ((rd_col < 3'(BOARD_COLS)) && (rd_row < 3'(BOARD_ROWS)))
      rd_piece = display[cell_index(rd_row, rd_col)];
  end

endmodule

// File: rtl/connect4_pixel_renderer.sv
// Two-stage pixel pipeline: stage 1 locates the cell and cursor, stage 2
// decides disc membership and colour. Output lags the coordinate by 2 clocks.
module connect4_pixel_renderer
  import connect4_pkg::*;
#(
  parameter int X0         = 96,
  parameter int Y0         = 64,
  parameter int CELL_LOG2  = 6,
  parameter int DISC_R2    = 784,
  parameter int BLINK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_start,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_row,
  input  logic [1:0] wr_piece,
  input  logic       clear,
  input  logic [2:0] cursor_col,
  input  logic       win_flash,
  output logic       vga_R,
  output logic       vga_G,
  output logic       vga_B,
  output logic       pix_valid
);

  localparam int CELL    = 1 << CELL_LOG2;
  localparam int BOARD_W = BOARD_COLS * CELL;
  localparam int BOARD_H = BOARD_ROWS * CELL;
  localparam int CUR_LO  = CELL / 4;
  localparam int CUR_HI  = 3 * CELL / 4;

  logic [10:0] dx, dy, cur_lo;
  logic        in_board, cursor_hit;
  logic [2:0]  col, board_row;
  logic [1:0]  rd_piece;

  logic                 s1_valid, s1_cursor, s1_in_board;
  logic [1:0]           s1_piece;
  logic [CELL_LOG2-1:0] s1_ox, s1_oy;

  logic [12:0]           ex, ey, dist2;
  logic                  in_disc, blanked;
  logic [2:0]            colour;
  logic [BLINK_LOG2-1:0] frame_cnt;

  // dx/dy are two's complement; bit 10 set means left of / above the board.
  assign dx        = {1'b0, pixel_x} - 11'(X0);
  assign dy        = {1'b0, pixel_y} - 11'(Y0);
  assign in_board  = !dx[10] && (dx < 11'(BOARD_W)) && !dy[10] && (dy < 11'(BOARD_H));
  assign col       = 3'(dx >> CELL_LOG2);
  assign board_row = 3'(BOARD_ROWS - 1) - 3'(dy >> CELL_LOG2);

  // Cursor is a square above the board, centred on the selected column.
  assign cur_lo     = 11'(X0 + CUR_LO) + (11'(cursor_col) << CELL_LOG2);
  assign cursor_hit = (cursor_col < 3'(BOARD_COLS))
                   && (pixel_y >= 10'(Y0 - CUR_HI)) && (pixel_y < 10'(Y0 - CUR_LO))
                   && ({1'b0, pixel_x} >= cur_lo)
                   && ({1'b0, pixel_x} < cur_lo + 11'(CUR_HI - CUR_LO));

  connect4_board_store u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_piece    (wr_piece),
    .clear       (clear),
    .frame_start (frame_start),
    .rd_col      (col),
    .rd_row      (board_row),
    .rd_piece    (rd_piece)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_cursor   <= 1'b0;
      s1_in_board <= 1'b0;
      s1_piece    <= EMPTY;
      s1_ox       <= '0;
      s1_oy       <= '0;
    end else begin
      s1_valid    <= video_on;
      s1_cursor   <= cursor_hit;
      s1_in_board <= in_board;
      s1_piece    <= in_board ? rd_piece : EMPTY;
      s1_ox       <= dx[CELL_LOG2-1:0];
      s1_oy       <= dy[CELL_LOG2-1:0];
    end
  end

  // Modular squares of the wrapped offsets equal the true squares here.
  assign ex      = 13'(s1_ox) - 13'(CELL / 2);
  assign ey      = 13'(s1_oy) - 13'(CELL / 2);
  assign dist2   = ex * ex + ey * ey;
  assign in_disc = s1_in_board && (dist2 < 13'(DISC_R2));
  assign blanked = win_flash && frame_cnt[BLINK_LOG2-1];

  always_comb begin
    colour = BLACK;
    if (s1_cursor)
      colour = WHITE;
    else if (s1_in_board && !in_disc)
      colour = BLUE;
    else if (in_disc && !blanked) begin
      case (piece_t'(s1_piece))
        P1:      colour = RED;
        P2:      colour = YELLOW;
        default: colour = BLACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vga_R, vga_G, vga_B} <= BLACK;
      pix_valid             <= 1'b0;
      frame_cnt             <= '0;
    end else begin
      {vga_R, vga_G, vga_B} <= s1_valid ? colour : BLACK;
      pix_valid             <= s1_valid;
      if (frame_start)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_connect4_pixel_renderer.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// every cycle against a behavioural board/pixel model.
module tb_connect4_pixel_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, frame_start, wr_en, clear, win_flash;
  logic [2:0] wr_col, wr_row, cursor_col;
  logic [1:0] wr_piece;
  logic       vga_R, vga_G, vga_B, pix_valid;

  int n_checks = 0;
  int n_fail   = 0;

  connect4_pixel_renderer dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .wr_en(wr_en),
    .wr_col(wr_col), .wr_row(wr_row), .wr_piece(wr_piece), .clear(clear),
    .cursor_col(cursor_col), .win_flash(win_flash),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {valid,rgb}=%b, expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit valid;
    bit cursor;
    bit in_board;
    bit disc;
    int piece;
  } s1_t;

  int         m_shadow [7][6];
  int         m_disp   [7][6];
  int         m_frames;
  s1_t        m_s1;
  logic [2:0] exp_rgb;
  logic       exp_valid;

  function automatic s1_t classify(int x, int y, bit vo, int cc);
    s1_t s;
    int dx = x - 96;
    int dy = y - 64;
    int ox, oy;
    s.valid    = vo;
    s.in_board = (dx >= 0) && (dx < 448) && (dy >= 0) && (dy < 384);
    s.cursor   = (cc < 7) && (y >= 16) && (y < 48) && (x >= 96 + cc*64 + 16) && (x < 96 + cc*64 + 48);
    s.disc     = 0;
    s.piece    = 0;
    if (s.in_board) begin
      ox      = dx % 64;
      oy      = dy % 64;
      s.disc  = ((ox-32)*(ox-32) + (oy-32)*(oy-32)) < 784;
      s.piece = m_disp[dx/64][5 - dy/64];
    end
    return s;
  endfunction

  function automatic logic [2:0] colour_of(s1_t s, bit blank);
    if (!s.valid) return 3'b000;
    if (s.cursor) return 3'b111;
    if (s.in_board && !s.disc) return 3'b001;
    if (s.in_board && s.disc && !blank && s.piece == 1) return 3'b100;
    if (s.in_board && s.disc && !blank && s.piece == 2) return 3'b110;
    return 3'b000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_shadow[c, r]) begin
        m_shadow[c][r] = 0;
        m_disp[c][r]   = 0;
      end
      m_frames  = 0;
      m_s1      = '{default: 0};
      exp_rgb   = 3'b000;
      exp_valid = 1'b0;
    end else begin
      exp_valid = m_s1.valid;
      exp_rgb   = colour_of(m_s1, win_flash && (((m_frames / 16) % 2) == 1));
      m_s1      = classify(int'(pixel_x), int'(pixel_y), video_on, int'(cursor_col));
      if (clear) begin
        foreach (m_shadow[c, r]) m_shadow[c][r] = 0;
      end else if (wr_en && wr_col <= 6 && wr_row <= 5) begin
        m_shadow[wr_col][wr_row] = (wr_piece == 3) ? 0 : int'(wr_piece);
      end
      if (frame_start) begin
        m_disp = m_shadow;
        m_frames++;
      end
    end
  end

  always @(negedge clk)
    check("model", {pix_valid, vga_R, vga_G, vga_B}, {exp_valid, exp_rgb});

  // ---------------- directed helpers ----------------
  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic write_cell(input int c, input int r, input int p);
    wr_en = 1'b1; wr_col = 3'(c); wr_row = 3'(r); wr_piece = 2'(p);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [2:0] rgb);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = 1'b1;
    repeat (2) @(negedge clk);
    check(name, {pix_valid, vga_R, vga_G, vga_B}, {1'b1, rgb});
  endtask

  initial begin
    rst_n = 1'b0; pixel_x = 10'd128; pixel_y = 10'd416; video_on = 1'b1;
    frame_start = 0; wr_en = 0; clear = 0; win_flash = 0;
    wr_col = 0; wr_row = 0; wr_piece = 0; cursor_col = 3'd7;
    repeat (3) @(negedge clk);
    check("reset_outputs", {pix_valid, vga_R, vga_G, vga_B}, 4'b0000);
    rst_n = 1'b1;

    probe("empty_bottom_left", 128, 416, 3'b000);
    write_cell(0, 0, 1);
    probe("p1_before_frame", 128, 416, 3'b000);
    pulse_frame();
    probe("p1_after_frame", 128, 416, 3'b100);
    probe("cell_corner_blue", 97, 65, 3'b001);
    probe("left_of_board", 95, 65, 3'b000);
    cursor_col = 3'd3;
    probe("cursor_col3", 308, 30, 3'b111);
    probe("cursor_left_edge", 304, 16, 3'b111);
    probe("cursor_right_out", 336, 30, 3'b000);
    cursor_col = 3'd7;
    probe("no_cursor", 308, 30, 3'b000);

    wr_en = 1'b1; wr_col = 3'd6; wr_row = 3'd5; wr_piece = 2'd2; frame_start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; frame_start = 1'b0; win_flash = 1'b1;
    probe("blink_phase0", 512, 96, 3'b110);
    repeat (14) pulse_frame();
    probe("blink_phase1", 512, 96, 3'b000);
    win_flash = 1'b0;
    probe("flash_off", 512, 96, 3'b110);
    win_flash = 1'b1;
    repeat (16) pulse_frame();
    probe("blink_phase0_again", 512, 96, 3'b110);

    wr_en = 1'b1; wr_col = 3'd2; wr_row = 3'd0; wr_piece = 2'd1; clear = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clear = 1'b0; frame_start = 1'b0;
    probe("clear_wins_col2", 256, 416, 3'b000);
    probe("clear_col0", 128, 416, 3'b000);
    probe("clear_col6", 512, 96, 3'b000);
    wr_en = 1'b1; wr_col = 3'd7; wr_row = 3'd0; wr_piece = 2'd1; frame_start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; frame_start = 1'b0;
    probe("bad_col_row1", 128, 352, 3'b000);
    probe("bad_col_row0", 128, 416, 3'b000);
    write_cell(4, 3, 3);
    pulse_frame();
    probe("reserved_piece", 96 + 4*64 + 32, 64 + 2*64 + 32, 3'b000);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        pixel_x = 10'($urandom_range(80, 560));
        pixel_y = 10'($urandom_range(0, 460));
      end else begin
        pixel_x = 10'($urandom_range(0, 1023));
        pixel_y = 10'($urandom_range(0, 1023));
      end
      video_on    = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 7) == 0);
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_col      = 3'($urandom_range(0, 7));
      wr_row      = 3'($urandom_range(0, 7));
      wr_piece    = 2'($urandom_range(0, 3));
      clear       = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 31) == 0) cursor_col = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) win_flash = ~win_flash;
      if (i == 2500) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset", {pix_valid, vga_R, vga_G, vga_B}, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end

    wr_en = 0; clear = 0; frame_start = 0; video_on = 0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
